// File: rtl/instr_sequencer_if.sv
// Handshake and status bundle between the issue sequencer and its
// fetch unit, data memory and pipeline consumers.
interface instr_sequencer_if #(
  parameter int RETIRE_W = 16
);
  logic [31:0]         instruction;
  logic                wait_instr;
  logic                instr_segv;
  logic                wait_data;
  logic                data_segv;
  logic                fault_clear;
  logic                fetch_req;
  logic [31:0]         ir;
  logic                ir_valid;
  logic                issue_alu;
  logic                issue_mem;
  logic                reg_we;
  logic                pc_inc;
  logic                pc_load;
  logic                fault;
  logic [1:0]          fault_cause;
  logic [2:0]          state;
  logic [RETIRE_W-1:0] retired_count;

  modport master (
    input  instruction,
    input  wait_instr,
    input  instr_segv,
    input  wait_data,
    input  data_segv,
    input  fault_clear,
    output fetch_req,
    output ir,
    output ir_valid,
    output issue_alu,
    output issue_mem,
    output reg_we,
    output pc_inc,
    output pc_load,
    output fault,
    output fault_cause,
    output state,
    output retired_count
  );

  modport slave (
    output instruction,
    output wait_instr,
    output instr_segv,
    output wait_data,
    output data_segv,
    output fault_clear,
    input  fetch_req,
    input  ir,
    input  ir_valid,
    input  issue_alu,
    input  issue_mem,
    input  reg_we,
    input  pc_inc,
    input  pc_load,
    input  fault,
    input  fault_cause,
    input  state,
    input  retired_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle issue sequencer: fetch, decode, ALU or load/store issue,
// retire; traps segmentation faults and memory timeouts into FAULT.
module instr_sequencer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int RETIRE_W    = 16
) (
  input logic              clk,
  input logic              rst_n,
  instr_sequencer_if.master seq_if
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    RETIRE = 3'd5,
    FAULT  = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_ISEG = 2'b01;
  localparam logic [1:0] CAUSE_DSEG = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [1:0]          cause_q, cause_d;
  logic [CW-1:0]       tmo_q, tmo_d;
  logic [RETIRE_W-1:0] ret_q, ret_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cause_q <= CAUSE_NONE;
      tmo_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    tmo_d   = tmo_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (seq_if.instr_segv) begin
          state_d = FAULT;
          cause_d = CAUSE_ISEG;
        end else if (!seq_if.wait_instr) begin
          ir_d    = seq_if.instruction;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (ir_q[0]) begin
          state_d = EXEC;
        end else begin
          state_d = MEM;
          tmo_d   = '0;
        end
      end
      EXEC: state_d = RETIRE;
      MEM: begin
        // segv beats completion, completion beats timeout
        if (seq_if.data_segv) begin
          state_d = FAULT;
          cause_d = CAUSE_DSEG;
        end else if (!seq_if.wait_data) begin
          state_d = RETIRE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = FAULT;
          cause_d = CAUSE_TMO;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      RETIRE: begin
        ret_d   = ret_q + RETIRE_W'(1);
        state_d = FETCH;
      end
      FAULT: begin
        if (seq_if.fault_clear) begin
          cause_d = CAUSE_NONE;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_fetch, in_dec, in_exec;
  logic in_mem, in_ret, in_fault;

  always_comb begin
    in_fetch = 1'b0;
    in_dec   = 1'b0;
    in_exec  = 1'b0;
    in_mem   = 1'b0;
    in_ret   = 1'b0;
    in_fault = 1'b0;
    unique case (1'b1)
      (state_q == FETCH):  in_fetch = 1'b1;
      (state_q == DECODE): in_dec   = 1'b1;
      (state_q == EXEC):   in_exec  = 1'b1;
      (state_q == MEM):    in_mem   = 1'b1;
      (state_q == RETIRE): in_ret   = 1'b1;
      (state_q == FAULT):  in_fault = 1'b1;
      default: ;
    endcase
  end

  assign seq_if.fetch_req     = in_fetch;
  assign seq_if.ir            = ir_q;
  assign seq_if.ir_valid      = in_dec | in_exec | in_mem | in_ret;
  assign seq_if.issue_alu     = in_exec;
  assign seq_if.issue_mem     = in_mem;
  assign seq_if.reg_we        = in_ret;
  assign seq_if.pc_inc        = in_ret & ~ir_q[1];
  assign seq_if.pc_load       = in_ret & ir_q[1];
  assign seq_if.fault         = in_fault;
  assign seq_if.fault_cause   = cause_q;
  assign seq_if.state         = state_q;
  assign seq_if.retired_count = ret_q;

endmodule
